// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear sequencer: button conditioning, tick prescaler
// and the IDLE/RUNNING/PAUSED/EXPIRED control FSM for the digit counter.
module stopwatch_ctrl #(
    parameter int c_TICK_DIV  = 100000,
    parameter int c_DB_CYCLES = 1000
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_BTN_START,
    input  logic i_BTN_CLEAR,
    input  logic i_MODE,
    input  logic i_ZERO,
    output logic o_TICK,
    output logic o_CLEAR,
    output logic o_TIMER,
    output logic o_RUNNING,
    output logic o_EXPIRED,
    output logic o_LAP_HOLD
);

    localparam int c_PW = $clog2(c_TICK_DIV);
    localparam int c_DW = $clog2(c_DB_CYCLES + 1);
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(c_TICK_DIV - 1);
    localparam logic [c_DW-1:0] c_DMAX = c_DW'(c_DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXP
    } state_e;

    // Button bit 0 is START, bit 1 is CLEAR
    logic [1:0]           sync1_q, sync1_d;
    logic [1:0]           sync2_q, sync2_d;
    logic [1:0]           lvl_q, lvl_d;
    logic [1:0]           dly_q, dly_d;
    logic [1:0]           press_q, press_d;
    logic [1:0][c_DW-1:0] db_cnt_q, db_cnt_d;

    state_e          state_q, state_d;
    logic [c_PW-1:0] presc_q, presc_d;
    logic            clear_q, clear_d;
    logic            timer_q, timer_d;
    logic            lap_q, lap_d;
    logic            init_q, init_d;
    logic            press_start, press_clr, expire;

    assign press_start = press_q[0];
    assign press_clr   = press_q[1];
    assign expire      = (state_q == S_RUN) && timer_q && i_ZERO;

    always_comb begin
        sync1_d  = {i_BTN_CLEAR, i_BTN_START};
        sync2_d  = sync1_q;
        dly_d    = lvl_q;
        press_d  = lvl_q & ~dly_q;
        lvl_d    = lvl_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == c_DMAX) begin
                lvl_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + c_DW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        clear_d = 1'b0;
        timer_d = timer_q;
        lap_d   = lap_q;
        init_d  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                timer_d = i_MODE;
                // A direction change re-preloads the counter (0000 or max)
                if (i_MODE != timer_q) clear_d = 1'b1;
                if (press_clr) begin
                    clear_d = 1'b1;
                end else if (press_start && !(i_MODE && i_ZERO)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                presc_d = (presc_q == c_PMAX) ? '0 : presc_q + c_PW'(1);
                if (expire) begin
                    state_d = S_EXP;
                end else if (press_clr) begin
                    lap_d = ~lap_q;
                end else if (press_start) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (press_clr) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    lap_d   = 1'b0;
                end else if (press_start) begin
                    state_d = S_RUN;
                end
            end
            S_EXP: begin
                presc_d = '0;
                if (press_clr || press_start) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    lap_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!init_q) clear_d = 1'b1;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            dly_q    <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
            state_q  <= S_IDLE;
            presc_q  <= '0;
            clear_q  <= 1'b0;
            timer_q  <= 1'b0;
            lap_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            lvl_q    <= lvl_d;
            dly_q    <= dly_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            presc_q  <= presc_d;
            clear_q  <= clear_d;
            timer_q  <= timer_d;
            lap_q    <= lap_d;
            init_q   <= init_d;
        end
    end

    assign o_TICK     = (state_q == S_RUN) && (presc_q == c_PMAX) && !expire;
    assign o_CLEAR    = clear_q;
    assign o_TIMER    = timer_q;
    assign o_RUNNING  = (state_q == S_RUN);
    assign o_EXPIRED  = (state_q == S_EXP);
    assign o_LAP_HOLD = lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with c_TICK_DIV=4, c_DB_CYCLES=3.
// Inputs change 2ns after a rising edge; cycle offsets are hand-computed.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;
    logic mode = 1'b0;
    logic zero = 1'b0;
    logic tick, clr, timer, running, expired, lap;

    int n_vec = 0;
    int n_bad = 0;
    int tick_cnt = 0;
    int clr_cnt = 0;
    int overlap = 0;
    int t0, c0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .c_TICK_DIV (4),
        .c_DB_CYCLES(3)
    ) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_BTN_START(btn_start),
        .i_BTN_CLEAR(btn_clear),
        .i_MODE     (mode),
        .i_ZERO     (zero),
        .o_TICK     (tick),
        .o_CLEAR    (clr),
        .o_TIMER    (timer),
        .o_RUNNING  (running),
        .o_EXPIRED  (expired),
        .o_LAP_HOLD (lap)
    );

    always @(negedge clk) begin
        if (tick) tick_cnt++;
        if (clr) clr_cnt++;
        if (tick && clr) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [5:0] outs();
        return {tick, clr, timer, running, expired, lap};
    endfunction

    initial begin
        // Reset and power-up clear
        #1;
        check_eq("reset_outs", outs(), 6'd0);
        step(2);
        check_eq("reset_held_clr", clr, 1'b0);
        rst_n = 1'b1;
        step(1);
        check_eq("por_clear", clr, 1'b1);
        step(1);
        check_eq("post_por_idle", outs(), 6'd0);

        // START held 10 cycles, count up
        step(2);
        btn_start = 1'b1;
        step(6);
        check_eq("start_pulse_cycle", running, 1'b0);
        step(1);
        check_eq("start_run", running, 1'b1);
        step(3);
        check_eq("first_tick", tick, 1'b1);
        t0 = tick_cnt;
        btn_start = 1'b0;
        step(20);
        check_eq("tick_rate", tick_cnt - t0, 5);
        check_eq("single_press", running, 1'b1);
        for (int b = 0; b < 3; b++) begin
            btn_start = 1'b1;
            step(b == 1 ? 2 : 1);
            btn_start = 1'b0;
            step(4);
        end
        step(8);
        check_eq("bounce_reject", running, 1'b1);

        // Reset mid-run
        rst_n = 1'b0;
        #1;
        check_eq("reset_midrun", outs(), 6'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check_eq("por_again", clr, 1'b1);
        step(1);
        check_eq("por_once", clr, 1'b0);

        // Pause with prescaler at 2, then resume
        step(2);
        btn_start = 1'b1;
        step(4);
        btn_start = 1'b0;
        step(3);
        check_eq("run_b", running, 1'b1);
        t0 = tick_cnt;
        step(3);
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(3);
        check_eq("pre_pause", running, 1'b1);
        step(1);
        check_eq("paused", running, 1'b0);
        check_eq("ticks_before_pause", tick_cnt - t0, 2);
        t0 = tick_cnt;
        step(50);
        check_eq("pause_no_tick", tick_cnt - t0, 0);
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(3);
        check_eq("resume_pulse", running, 1'b0);
        step(1);
        check_eq("resumed", running, 1'b1);
        check_eq("resume_p2", tick, 1'b0);
        step(1);
        check_eq("resume_tick", tick, 1'b1);
        step(4);
        check_eq("resume_tick2", tick, 1'b1);

        // Lap hold toggling while running
        btn_clear = 1'b1;
        step(3);
        btn_clear = 1'b0;
        step(3);
        check_eq("lap_pulse", lap, 1'b0);
        step(1);
        check_eq("lap_on", lap, 1'b1);
        t0 = tick_cnt;
        step(8);
        check_eq("lap_ticks", tick_cnt - t0, 2);
        check_eq("lap_running", running, 1'b1);
        btn_clear = 1'b1;
        step(3);
        btn_clear = 1'b0;
        step(4);
        check_eq("lap_off", lap, 1'b0);

        // Pause, then START+CLEAR together
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(4);
        check_eq("pause2", running, 1'b0);
        step(2);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        step(3);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(3);
        check_eq("both_pulse", clr, 1'b0);
        step(1);
        check_eq("both_clear", clr, 1'b1);
        check_eq("both_idle", running, 1'b0);
        step(1);
        check_eq("both_clear_once", clr, 1'b0);
        step(5);
        check_eq("both_stay_idle", running, 1'b0);

        // Mode change in IDLE, timer run, expiry
        step(3);
        mode = 1'b1;
        step(1);
        check_eq("mode_follow", timer, 1'b1);
        check_eq("mode_clear", clr, 1'b1);
        step(1);
        check_eq("mode_clear_once", clr, 1'b0);
        step(2);
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(4);
        check_eq("timer_run", running, 1'b1);
        mode = 1'b0;
        step(1);
        check_eq("mode_frozen", timer, 1'b1);
        mode = 1'b1;
        step(2);
        zero = 1'b1;
        #1;
        check_eq("tick_forced_off", tick, 1'b0);
        check_eq("not_yet_expired", expired, 1'b0);
        step(1);
        check_eq("expired", expired, 1'b1);
        check_eq("exp_not_running", running, 1'b0);
        c0 = clr_cnt;
        btn_clear = 1'b1;
        step(3);
        btn_clear = 1'b0;
        step(3);
        check_eq("exp_hold", expired, 1'b1);
        step(1);
        check_eq("exp_cleared", expired, 1'b0);
        check_eq("exp_clear", clr, 1'b1);
        step(2);
        check_eq("exp_one_clear", clr_cnt - c0, 1);

        // START ignored in IDLE with timer mode at zero
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(6);
        check_eq("start_ignored", running, 1'b0);
        check_eq("ignored_no_exp", expired, 1'b0);

        check_eq("tick_clear_excl", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
